// File: rtl/reg_write_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
// Shared constants and types for the register-write scoreboard.
//   NUM_REGS : architectural registers (register 0 is never tracked)
//   ADDR_W   : register address width
//   CNT_W    : per-register pending counter width
//   CNT_MAX  : largest pending count a single register can hold
// -----------------------------------------------------------------------------
package scoreboard_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (2 ** CNT_W) - 1;
    localparam int OUT_W    = ADDR_W + CNT_W;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [OUT_W-1:0]  out_cnt_t;

    // Register 0 is hardwired to zero, so writes to it never need tracking.
    function automatic logic is_tracked(input addr_t addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/reg_write_scoreboard_decoder.sv
// -----------------------------------------------------------------------------
// reg_addr_decoder_5to32
// Decodes a register address plus enable into a one-hot register select.
// Bit 0 is forced low because register 0 is never tracked.
// Ports:
//   addr_i   : register address
//   en_i     : decode enable; all outputs low when 0
//   onehot_o : one-hot select, NUM_REGS wide
// -----------------------------------------------------------------------------
module reg_addr_decoder_5to32
    import scoreboard_pkg::*;
(
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        if (gi == 0) begin : g_zero
            assign onehot_o[gi] = 1'b0;
        end else begin : g_sel
            assign onehot_o[gi] = en_i && (addr_i == addr_t'(gi));
        end
    end

endmodule

// File: rtl/reg_write_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_write_scoreboard
// Tracks register-file writes in flight between issue (ID) and writeback (WB)
// with one small pending counter per register, and stalls an issuing
// instruction whose sources still have unretired writes.
// Ports:
//   Clk, Rst          : clock, synchronous active-high reset
//   IssueValid        : instruction present in ID
//   IssueRegWrite     : that instruction writes the register file
//   IssueDest         : its destination register
//   RsAddr, RtAddr    : its source registers
//   WbValid, WbDest   : writeback strobe and destination
//   RsPending/RtPending : source has an outstanding write
//   Stall             : issue must hold this cycle
//   OutstandingCnt    : total writes in flight (registered)
//   Error             : sticky, writeback to a register with nothing pending
// Optional build macro: SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback
// of the last pending write clear RsPending/RtPending immediately.
// -----------------------------------------------------------------------------
module reg_write_scoreboard
    import scoreboard_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    IssueValid,
    input  logic                    IssueRegWrite,
    input  logic [ADDR_W-1:0]       IssueDest,
    input  logic [ADDR_W-1:0]       RsAddr,
    input  logic [ADDR_W-1:0]       RtAddr,
    input  logic                    WbValid,
    input  logic [ADDR_W-1:0]       WbDest,
    output logic                    RsPending,
    output logic                    RtPending,
    output logic                    Stall,
    output logic [ADDR_W+CNT_W-1:0] OutstandingCnt,
    output logic                    Error
);

    cnt_t [NUM_REGS-1:0] cnt_q;
    cnt_t [NUM_REGS-1:0] cnt_d;
    out_cnt_t            out_cnt_q;
    out_cnt_t            out_cnt_d;
    logic                error_q;
    logic                error_d;

    logic [NUM_REGS-1:0] issue_oh;
    logic [NUM_REGS-1:0] wb_oh;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] err_vec;
    logic                issue_en;
    logic                accept;
    logic                retire;
    logic                dest_sat;
    logic                rs_bypass;
    logic                rt_bypass;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last pending write retiring this cycle is visible to the reader now.
    assign rs_bypass = WbValid && (WbDest == RsAddr) && (cnt_q[RsAddr] == cnt_t'(1));
    assign rt_bypass = WbValid && (WbDest == RtAddr) && (cnt_q[RtAddr] == cnt_t'(1));
`else
    assign rs_bypass = 1'b0;
    assign rt_bypass = 1'b0;
`endif

    assign RsPending = is_tracked(RsAddr) && (cnt_q[RsAddr] != '0) && !rs_bypass;
    assign RtPending = is_tracked(RtAddr) && (cnt_q[RtAddr] != '0) && !rt_bypass;

    // A saturated destination counter cannot absorb another write.
    assign dest_sat  = IssueRegWrite && (cnt_q[IssueDest] == cnt_t'(CNT_MAX));
    assign Stall     = IssueValid && (RsPending || RtPending || dest_sat);
    assign issue_en  = IssueValid && IssueRegWrite && !Stall;

    // The decoders drop register 0, so issue/WB to it never touch a counter.
    reg_addr_decoder_5to32 u_issue_dec (
        .addr_i   (IssueDest),
        .en_i     (issue_en),
        .onehot_o (issue_oh)
    );

    reg_addr_decoder_5to32 u_wb_dec (
        .addr_i   (WbDest),
        .en_i     (WbValid),
        .onehot_o (wb_oh)
    );

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
        assign dec_vec[gi] = wb_oh[gi] && (cnt_q[gi] != '0);
        assign err_vec[gi] = wb_oh[gi] && (cnt_q[gi] == '0);
        // Simultaneous accept and retire on one register cancel out.
        assign cnt_d[gi]   = (issue_oh[gi] && !dec_vec[gi]) ? cnt_q[gi] + cnt_t'(1) :
                             (dec_vec[gi] && !issue_oh[gi]) ? cnt_q[gi] - cnt_t'(1) :
                             cnt_q[gi];
    end

    assign accept    = |issue_oh;
    assign retire    = |dec_vec;
    assign out_cnt_d = out_cnt_q + out_cnt_t'(accept) - out_cnt_t'(retire);
    assign error_d   = error_q || (|err_vec);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q     <= '0;
            out_cnt_q <= '0;
            error_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
            error_q   <= error_d;
        end
    end

    assign OutstandingCnt = out_cnt_q;
    assign Error          = error_q;

endmodule
